// File: rtl/traffic_light_controller.sv
// Two-road intersection sequencer with tick-timed phases and optional pedestrian walk phase.
// Define TRAFFIC_PED_EN to build in the PED_WALK state, request latch and ack.
module traffic_light_controller #(
    parameter int unsigned GREEN_NS = 10,
    parameter int unsigned GREEN_EW = 10,
    parameter int unsigned YELLOW   = 3,
    parameter int unsigned ALL_RED  = 1,
    parameter int unsigned WALK     = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       ped_req,
    output logic       ped_ack,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic [7:0] remaining
);

    typedef enum logic [2:0] {
        StNsGreen,
        StNsYellow,
        StRedA,
        StEwGreen,
        StEwYellow,
        StRedB,
        StPedWalk
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_d;

    function automatic logic [7:0] load_val(input state_e st);
        case (st)
            StNsGreen:            load_val = 8'(GREEN_NS - 1);
            StEwGreen:            load_val = 8'(GREEN_EW - 1);
            StNsYellow,
            StEwYellow:           load_val = 8'(YELLOW - 1);
            StPedWalk:            load_val = 8'(WALK - 1);
            default:              load_val = 8'(ALL_RED - 1);
        endcase
    endfunction

    // Lamp encoding is {red, yellow, green}.
    function automatic logic [2:0] ns_of(input state_e st);
        case (st)
            StNsGreen:  ns_of = 3'b001;
            StNsYellow: ns_of = 3'b010;
            default:    ns_of = 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] ew_of(input state_e st);
        case (st)
            StEwGreen:  ew_of = 3'b001;
            StEwYellow: ew_of = 3'b010;
            default:    ew_of = 3'b100;
        endcase
    endfunction

`ifdef TRAFFIC_PED_EN
    logic ped_latch_q, ped_latch_d;
    logic next_dir_q, next_dir_d;  // 1: EW green follows the walk, 0: NS green
    logic ped_ack_d;
`else
    logic unused_ped_req;
    assign unused_ped_req = ped_req;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = remaining;
`ifdef TRAFFIC_PED_EN
        ped_latch_d = ped_latch_q;
        next_dir_d  = next_dir_q;
        ped_ack_d   = 1'b0;
        if (ped_req && !ped_latch_q) begin
            ped_latch_d = 1'b1;
            ped_ack_d   = 1'b1;
        end
`endif
        if (tick) begin
            if (remaining != 8'd0) begin
                cnt_d = remaining - 8'd1;
            end else begin
                case (state_q)
                    StNsGreen:  state_d = StNsYellow;
                    StNsYellow: state_d = StRedA;
                    StRedA:     state_d = StEwGreen;
                    StEwGreen:  state_d = StEwYellow;
                    StEwYellow: state_d = StRedB;
                    StRedB:     state_d = StNsGreen;
`ifdef TRAFFIC_PED_EN
                    default:    state_d = next_dir_q ? StEwGreen : StNsGreen;
`else
                    default:    state_d = StNsGreen;
`endif
                endcase
`ifdef TRAFFIC_PED_EN
                // Service uses the latch as held before this edge; a same-cycle
                // request is latched above and waits for the next all-red.
                if (state_q == StRedA || state_q == StRedB) begin
                    next_dir_d = (state_q == StRedA);
                    if (ped_latch_q) begin
                        state_d     = StPedWalk;
                        ped_latch_d = 1'b0;
                    end
                end
`endif
                cnt_d = load_val(state_d);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StNsGreen;
            remaining <= 8'(GREEN_NS - 1);
            ns_light  <= 3'b001;
            ew_light  <= 3'b100;
            walk      <= 1'b0;
            ped_ack   <= 1'b0;
`ifdef TRAFFIC_PED_EN
            ped_latch_q <= 1'b0;
            next_dir_q  <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            remaining <= cnt_d;
            ns_light  <= ns_of(state_d);
            ew_light  <= ew_of(state_d);
`ifdef TRAFFIC_PED_EN
            walk        <= (state_d == StPedWalk);
            ped_ack     <= ped_ack_d;
            ped_latch_q <= ped_latch_d;
            next_dir_q  <= next_dir_d;
`else
            walk        <= 1'b0;
            ped_ack     <= 1'b0;
`endif
        end
    end

endmodule

// File: doc/traffic_light_controller.md
# traffic_light_controller

Sequencing controller for the two-road intersection: advances the north-south and east-west signal heads through green, yellow and all-red phases and inserts a pedestrian walk phase on request. Every phase duration is counted in ticks. `tick` is a one-`clk`-cycle pulse supplied by the intersection's clock-divider stage (1 Hz nominal). Outputs drive the light decoders and the countdown display directly.

## Interface
- `GREEN_NS`, default 10: NS green duration, in ticks (1..255).
- `GREEN_EW`, default 10: EW green duration, in ticks (1..255).
- `YELLOW`, default 3: yellow duration for either road, in ticks (1..255).
- `ALL_RED`, default 1: all-red clearance duration, in ticks (1..255).
- `WALK`, default 5: pedestrian walk duration, in ticks (1..255).
- `clk` input 1: single system clock; all logic is on its rising edge.
- `rst` input 1: reset, synchronous, active-low.
- `tick` input 1: phase-time enable, a one-cycle pulse, synchronous to `clk`.
- `ped_req` input 1: pedestrian request, level or pulse.
- `ped_ack` output 1: one-cycle pulse when a request is accepted.
- `ns_light` output 3: NS head as {red, yellow, green}, one-hot.
- `ew_light` output 3: EW head as {red, yellow, green}, one-hot.
- `walk` output 1: pedestrian walk lamp.
- `remaining` output 8: ticks left in the current phase, minus one.

## Operation
- States: NS_GREEN → NS_YELLOW → RED_A → EW_GREEN → EW_YELLOW → RED_B → NS_GREEN; PED_WALK is optional.
- Lights per state:
  - NS_GREEN: NS=001, EW=100.
  - NS_YELLOW: NS=010, EW=100.
  - EW_GREEN: NS=100, EW=001.
  - EW_YELLOW: NS=100, EW=010.
  - RED_A, RED_B and PED_WALK: NS=100, EW=100.
- `walk`=1 only in PED_WALK.
- Phase counter:
  - The 8-bit counter loads duration−1 on state entry.
  - It decrements by 1 on each cycle where `tick`=1 and counter≠0.
  - On a cycle where `tick`=1 and counter=0, the FSM moves to the next state and reloads.
  - `remaining` = counter.
  - With no `tick`, the state and counter hold indefinitely.
- Pedestrian latch:
  - In a cycle where `ped_req`=1 and the latch is clear, the latch is set at the next edge and `ped_ack`=1 for exactly that following cycle.
  - Requests while the latch is set are ignored, with no ack.
- Pedestrian service:
  - On leaving RED_A or RED_B with the latch set, the FSM enters PED_WALK instead of the next green, and the latch clears on that entry.
  - PED_WALK exits to the green that would have followed: EW_GREEN after RED_A, NS_GREEN after RED_B. A 1-bit `next_dir` register holds this.
- Greens and yellows are never shortened or extended by requests.

## Timing
- Reset (`rst`=0 at an edge) puts the block in:
  - state NS_GREEN, counter GREEN_NS−1;
  - `ns_light`=001, `ew_light`=100, `walk`=0, `ped_ack`=0;
  - pedestrian latch clear, `next_dir`=EW.
- Reset mid-phase, including mid-PED_WALK, takes effect at the next edge and discards any pending request.
- Reset has priority over `tick` and `ped_req` in the same cycle.
- All outputs are registered and change only on `clk` edges.
- State, lights and `remaining` update on the edge following the terminal tick, so a phase of duration D lasts exactly D ticks.
- Simultaneous events: `ped_req` in the same cycle as the terminal tick of RED_A or RED_B is not served in that transition. The FSM uses the latch value held before the edge. The request is latched and acked normally, and is served at the next all-red.
- `ped_req` held high continuously is acked once per service. It re-latches in the cycle after PED_WALK is entered, which gives a second ack and service at the following all-red.
- Duration parameters of 0 are illegal; behaviour is undefined and the bench does not exercise them.

## Configuration
- `TRAFFIC_PED_EN` defined:
  - PED_WALK state, pedestrian latch, `next_dir` and `ped_ack` logic are compiled in as described above.
- `TRAFFIC_PED_EN` undefined:
  - `ped_req` is ignored;
  - `ped_ack` and `walk` are tied to 0;
  - the FSM is the six-state cycle only, and the `WALK` parameter is unused.

## Test plan
Bench parameters are GREEN_NS=4, GREEN_EW=3, YELLOW=2, ALL_RED=1, WALK=2. `tick` is pulsed every 4th cycle unless stated.
- Reset, then no request for 28 ticks → state sequence NS_GREEN(4) NS_YELLOW(2) RED_A(1) EW_GREEN(3) EW_YELLOW(2) RED_B(1) repeating, with `remaining` counting 3,2,1,0 in NS_GREEN, and `walk`=0 throughout.
- One-cycle `ped_req` during NS_GREEN → `ped_ack`=1 for one cycle on the next cycle. After RED_A the FSM shows PED_WALK for 2 ticks (`walk`=1, both heads 100), then EW_GREEN.
- `ped_req` in the cycle of RED_A's terminal tick → FSM goes RED_A→EW_GREEN, `ped_ack` pulses once, and PED_WALK follows RED_B, then NS_GREEN.
- Three `ped_req` pulses during one EW_GREEN → exactly one `ped_ack` and one PED_WALK.
- `tick` held low for 100 cycles mid-NS_YELLOW → state, lights and `remaining` unchanged. `rst`=0 for one cycle → NS_GREEN, `remaining`=3, latch clear.
- Build without `TRAFFIC_PED_EN`, with `ped_req`=1 constantly → `ped_ack`=0 and `walk`=0 always, and the six-state cycle matches the first scenario.
